// File: rtl/tick_pkg.sv
// tick_pkg: shared constants and channel state encoding for the tick scheduler.
package tick_pkg;
   localparam int NCH = 4;
   localparam int PW  = 16;
   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
endpackage

// File: rtl/tick_channel.sv
// tick_channel: one timer channel counting base ticks, emitting tick pulses and a divided clock.
module tick_channel
   import tick_pkg::*;
(
   input  logic          clkin,
   input  logic          rst,
   input  logic          base_tick,
   input  logic          cfg_we,
   input  logic [PW-1:0] cfg_period,
   input  logic          cfg_oneshot,
   input  logic          start,
   input  logic          stop,
   output logic          tick,
   output logic          clk_out,
   output logic          busy
);
   state_t state_q, state_d;
   logic [PW-1:0] period_q, period_d, count_q, count_d;
   logic oneshot_q, oneshot_d, tick_q, tick_d, clk_out_q, clk_out_d, expire;

   always_comb begin
      period_d  = cfg_we ? ((cfg_period == '0) ? PW'(1) : cfg_period) : period_q;
      oneshot_d = cfg_we ? cfg_oneshot : oneshot_q;
      // start and stop both pre-empt an expiry in the same cycle, so no tick escapes
      expire    = (state_q == RUN) && base_tick && (count_q == PW'(1)) && !start && !stop;
      state_d   = stop ? IDLE : start ? RUN : (expire && oneshot_q) ? IDLE : state_q;
      count_d   = (start || expire) ? period_d :
                  ((state_q == RUN) && base_tick && !stop) ? count_q - PW'(1) : count_q;
      tick_d    = expire;
      clk_out_d = !stop && (clk_out_q ^ expire);
   end

   always_ff @(posedge clkin) begin
      if (rst) begin
         state_q   <= IDLE;
         period_q  <= PW'(1);
         oneshot_q <= 1'b0;
         count_q   <= '0;
         tick_q    <= 1'b0;
         clk_out_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         period_q  <= period_d;
         oneshot_q <= oneshot_d;
         count_q   <= count_d;
         tick_q    <= tick_d;
         clk_out_q <= clk_out_d;
      end
   end

   assign tick    = tick_q;
   assign clk_out = clk_out_q;
   assign busy    = (state_q == RUN);
endmodule

// File: rtl/tick_scheduler.sv
// tick_scheduler: shared prescaler feeding four independent periodic/one-shot tick channels.
module tick_scheduler
   import tick_pkg::*;
#(
   parameter int CLK_FREQ  = 50000000,
   parameter int BASE_FREQ = 1000,
   parameter int PRESCALE  = CLK_FREQ / BASE_FREQ
)(
   input  logic           clkin,
   input  logic           rst,
   input  logic           cfg_we,
   input  logic [1:0]     cfg_ch,
   input  logic [PW-1:0]  cfg_period,
   input  logic           cfg_oneshot,
   input  logic [NCH-1:0] ch_start,
   input  logic [NCH-1:0] ch_stop,
   output logic [NCH-1:0] tick,
   output logic [NCH-1:0] clk_out,
   output logic [NCH-1:0] busy,
   output logic           base_tick
);
   localparam int PCW = $clog2(PRESCALE);
   localparam logic [PCW-1:0] PMAX = PCW'(PRESCALE - 1);

   logic [PCW-1:0] pcnt_q, pcnt_d;
   logic base_tick_q, base_tick_d;

   always_comb begin
      pcnt_d      = (pcnt_q == PMAX) ? '0 : pcnt_q + PCW'(1);
      base_tick_d = (pcnt_q == PMAX);
   end

   always_ff @(posedge clkin) begin
      if (rst) begin
         pcnt_q      <= '0;
         base_tick_q <= 1'b0;
      end else begin
         pcnt_q      <= pcnt_d;
         base_tick_q <= base_tick_d;
      end
   end

   assign base_tick = base_tick_q;

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      tick_channel u_ch (
         .clkin       (clkin),
         .rst         (rst),
         .base_tick   (base_tick_q),
         .cfg_we      (cfg_we && (cfg_ch == 2'(i))),
         .cfg_period  (cfg_period),
         .cfg_oneshot (cfg_oneshot),
         .start       (ch_start[i]),
         .stop        (ch_stop[i]),
         .tick        (tick[i]),
         .clk_out     (clk_out[i]),
         .busy        (busy[i])
      );
   end
endmodule
